mult_iter_unit: RTL and testbench



---
 rtl/mult_iter_unit.sv | 139 +++++++++++++
 tb/tb_mult_iter_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_iter_unit.sv
// Iterative shift-and-add multiplier for the EX stage: one K-bit multiplier chunk per cycle.
// Optional macro MULT_HIGH_EN widens the accumulator and adds the result_hi (MULHU) output.
module mult_iter_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CYCLES = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              stall,
    output logic              result_valid,
`ifdef MULT_HIGH_EN
    output logic [DATA_W-1:0] result_hi,
`endif
    output logic [DATA_W-1:0] result
);

    localparam int unsigned K     = DATA_W / CYCLES;
    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
`ifdef MULT_HIGH_EN
    localparam int unsigned ACC_W = 2 * DATA_W;
`else
    localparam int unsigned ACC_W = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  result_q, result_d;
`ifdef MULT_HIGH_EN
    logic [DATA_W-1:0]  result_hi_q, result_hi_d;
`endif

    logic [31:0]        shamt;
    logic [K-1:0]       chunk;
    logic [ACC_W-1:0]   acc_next;
    logic               accept;

    // Shifting the truncated partial product is equivalent to truncating the shifted one,
    // since bits above ACC_W can only move further out of range.
    always_comb begin
        shamt    = 32'(count_q) * K;
        chunk    = K'(b_q >> shamt);
        acc_next = acc_q + (ACC_W'((DATA_W + K)'(a_q) * (DATA_W + K)'(chunk)) << shamt);
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_d    = result_q;
`ifdef MULT_HIGH_EN
        result_hi_d = result_hi_q;
`endif
        accept      = 1'b0;

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: accept = start;
                StBusy: begin
                    acc_d   = acc_next;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) begin
                        result_d    = acc_next[DATA_W-1:0];
`ifdef MULT_HIGH_EN
                        result_hi_d = acc_next[2*DATA_W-1:DATA_W];
`endif
                        state_d     = StDone;
                    end
                end
                StDone: begin
                    accept  = start;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase

            if (accept) begin
                a_d     = op_a;
                b_d     = op_b;
                acc_d   = '0;
                count_d = '0;
                state_d = StBusy;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            result_q    <= '0;
`ifdef MULT_HIGH_EN
            result_hi_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            result_q    <= result_d;
`ifdef MULT_HIGH_EN
            result_hi_q <= result_hi_d;
`endif
        end
    end

    // Stall drops in DONE unless another MUL follows, letting EX capture the result.
    always_comb begin
        stall        = ((state_q == StIdle) && start) || (state_q == StBusy) ||
                       ((state_q == StDone) && start);
        result_valid = (state_q == StDone);
        result       = result_q;
`ifdef MULT_HIGH_EN
        result_hi    = result_hi_q;
`endif
    end

endmodule

// File: tb/tb_mult_iter_unit.sv
// Directed bench for mult_iter_unit with a scoreboard queue of expected products.
// Honours MULT_HIGH_EN for the result_hi port.
module tb_mult_iter_unit;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CYCLES = 4;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              start;
    logic              flush;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              stall;
    logic              result_valid;
    logic [DATA_W-1:0] result;
`ifdef MULT_HIGH_EN
    logic [DATA_W-1:0] result_hi;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    logic [31:0] exp_q[$];

    mult_iter_unit #(
        .DATA_W(DATA_W),
        .CYCLES(CYCLES)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .flush       (flush),
        .op_a        (op_a),
        .op_b        (op_b),
        .stall       (stall),
        .result_valid(result_valid),
`ifdef MULT_HIGH_EN
        .result_hi   (result_hi),
`endif
        .result      (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        exp_q.push_back(p);
    endtask

    // Scoreboard: every result_valid pulse must match the oldest outstanding product.
    always @(negedge clk) begin
        if (arst_n && result_valid) begin
            logic [31:0] e;
            pulses++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_result", 32'(result), 32'(e[15:0]));
`ifdef MULT_HIGH_EN
                chk("sb_result_hi", 32'(result_hi), 32'(e[31:16]));
`endif
            end
        end
    end

    // One-shot op: checks stall through the op, latency, DONE-cycle stall and result hold.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string tag);
        int n;
        logic [31:0] p;
        p = 32'(a) * 32'(b);
        op_a = a;
        op_b = b;
        start = 1'b1;
        push_exp(a, b);
        #1;
        chk({tag, "_stall_start"}, 32'(stall), 32'd1);
        tick();
        start = 1'b0;
        n = 0;
        while (!result_valid && n < 10) begin
            chk({tag, "_stall_busy"}, 32'(stall), 32'd1);
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(result_valid), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(CYCLES));
        chk({tag, "_stall_done"}, 32'(stall), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(p[15:0]));
        tick();
        chk({tag, "_valid_drop"}, 32'(result_valid), 32'd0);
        chk({tag, "_hold"}, 32'(result), 32'(p[15:0]));
`ifdef MULT_HIGH_EN
        chk({tag, "_hold_hi"}, 32'(result_hi), 32'(p[31:16]));
`endif
    endtask

    initial begin
        int p0;
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        arst_n = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        #3;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        start = 1'b1;
        #1;
        chk("rst_stall_follows_start", 32'(stall), 32'd1);
        start = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        tick();

        run_op(16'h0003, 16'h0005, "basic");
        run_op(16'hFFFF, 16'hFFFF, "full");

        // Back-to-back with start held; mid-op operand changes must be ignored.
        op_a  = 16'h0012;
        op_b  = 16'h0034;
        start = 1'b1;
        push_exp(16'h0012, 16'h0034);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("b2b_stall", 32'(stall), 32'd1);
            if (i == 5) begin
                chk("b2b_first_valid", 32'(result_valid), 32'd1);
                chk("b2b_first_result", 32'(result), 32'h03A8);
                push_exp(16'h0100, 16'h0100);
            end else begin
                chk("b2b_no_valid", 32'(result_valid), 32'd0);
            end
            tick();
            if (i == 0) begin
                op_a = 16'h0100;
                op_b = 16'h0100;
            end
        end
        start = 1'b0;
        #1;
        chk("b2b_second_valid", 32'(result_valid), 32'd1);
        chk("b2b_second_result", 32'(result), 32'h0000);
        chk("b2b_second_stall", 32'(stall), 32'd0);
        tick();

        // start asserted while busy must not re-latch or add a pulse.
        p0 = pulses;
        op_a  = 16'h0011;
        op_b  = 16'h0003;
        start = 1'b1;
        push_exp(16'h0011, 16'h0003);
        tick();
        op_a = 16'h7777;
        op_b = 16'h5555;
        tick();
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("ignore_result", 32'(result), 32'h0033);
        chk("ignore_pulses", 32'(pulses - p0), 32'd1);

        // Flush after two busy cycles.
        p0 = pulses;
        op_a  = 16'h0007;
        op_b  = 16'h0009;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("flush_stall_before", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_valid", 32'(result_valid), 32'd0);
        chk("flush_result_hold", 32'(result), 32'h0033);
        for (int i = 0; i < 6; i++) tick();
        chk("flush_no_pulse", 32'(pulses - p0), 32'd0);

        // Flush beats start in IDLE.
        op_a  = 16'h0005;
        op_b  = 16'h0005;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_idle_no_accept", 32'(stall), 32'd0);
        tick();
        chk("flush_idle_no_accept2", 32'(stall), 32'd0);
        chk("flush_idle_result", 32'(result), 32'h0033);

        // Asynchronous reset mid-op, released before the next edge.
        op_a  = 16'h0009;
        op_b  = 16'h000B;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1 arst_n = 1'b0;
        #1;
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_valid", 32'(result_valid), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
`ifdef MULT_HIGH_EN
        chk("arst_result_hi", 32'(result_hi), 32'd0);
`endif
        #1 arst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("arst_lost_result", 32'(result), 32'd0);
        run_op(16'h0002, 16'h0004, "post_rst");

        for (int i = 0; i < 4; i++) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
